power_integrator: RTL
=====================

Name: power_integrator

Overview:
- Multi-stage magnitude-squared power detector with window integration, for the complex baseband chain.
- Pipelines |x|² = re² + im² per sample at full precision.
- Accumulates |x|² over a run-time-selectable window of 2^k samples and emits either the window sum or the window mean.
- Feeds detection / threshold logic downstream of the channel filters.

Parameters:
- IN_W, 16, signed width of re/im.
- LOG2_LEN_MAX, 10, maximum log2 of the integration window length.
- MEAN_MODE, 0, 0 = output window sum, 1 = output window mean (sum >> k).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- re  in  IN_W  signed in-phase sample.
- im  in  IN_W  signed quadrature sample.
- in_en  in  1  sample valid, one sample per asserted cycle.
- log2_len  in  $clog2(LOG2_LEN_MAX+1)  window length k; sampled at window start.
- clear  in  1  synchronous abort of the current window.
- power  out  2*IN_W  unsigned per-sample |x|².
- power_en  out  1  power valid pulse.
- acc_power  out  2*IN_W+LOG2_LEN_MAX  unsigned window result.
- acc_en  out  1  window result valid pulse (one cycle).
- sample_cnt  out  LOG2_LEN_MAX+1  samples accumulated in the current window.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs, pipeline valids, accumulator and counter go to 0. Datapath registers are also cleared.
- Stage 1 registers re/im. Stage 2 registers the signed squares. Stage 3 registers their unsigned sum.
- power/power_en appear exactly 3 cycles after the in_en cycle. Back-to-back in_en gives back-to-back power_en. Bubbles are preserved.
- Width rule: power is 2*IN_W bits, so no overflow at the corner. Example: re = im = −2^(IN_W−1) gives power = 2^(2*IN_W−1).
- Accumulator width is 2*IN_W+LOG2_LEN_MAX. It cannot overflow for any legal k.
- log2_len values above LOG2_LEN_MAX are clamped to LOG2_LEN_MAX.
- Window FSM states:
  - IDLE: k latched from log2_len on the first power_en after reset/clear/window end; sample_cnt=0.
  - ACCUM: each power_en adds power and increments sample_cnt.
  - On the power_en that makes sample_cnt = 2^k: the next cycle drives acc_power = total (MEAN_MODE=1: total >> k, truncating) with acc_en=1 for one cycle.
  - In that same cycle the accumulator and count return to 0, and the FSM re-enters IDLE. A power_en arriving in that cycle starts the next window with no sample lost.
- k=0: every sample produces acc_en one cycle after its power_en; acc_power = power.
- acc_en latency is 4 cycles from the in_en of a window's last sample.
- acc_power holds its value between acc_en pulses.
- clear: the next edge zeroes the accumulator and sample_cnt and enters IDLE. clear does not flush the squaring pipeline.
- clear coincident with power_en: clear wins and that sample is discarded from the window. power_en itself still pulses.
- clear coincident with a window completing: acc_en is suppressed.
- log2_len changes mid-window have no effect until the next window start.

Optional Feature:
- Macro: POWER_INTEGRATOR_PEAK_EN.
- With the macro defined: adds output peak_power (2*IN_W).
  - peak_power is updated with the maximum power seen in the window.
  - It is presented in the same cycle as acc_en and held until the next acc_en.
  - It resets to 0 and is cleared alongside the accumulator.
- Without the macro: the port and its compare logic are absent; all other behaviour is identical.

Decomposition:
- Shared package power_pkg holds:
  - localparams for the default IN_W and LOG2_LEN_MAX;
  - the window FSM state enum (IDLE, ACCUM);
  - a function for accumulator width.
- One sub-module, mag_sq_pipe: the 3-stage re²+im² pipeline with valid. It is reusable by other detectors.
- The window FSM and accumulator stay in the top module.

Test Plan:
- re=3, im=−4, single in_en, log2_len=0 → power=25 with power_en at cycle+3; acc_power=25 with acc_en at cycle+4.
- re=im=−32768 (IN_W=16) → power=0x8000_0000, no wrap.
- log2_len=2, MEAN_MODE=0, powers 1,4,9,16 back-to-back → acc_power=30, single acc_en.
  - Repeat with MEAN_MODE=1 → acc_power=7.
- log2_len=3, continuous in_en for 24 samples of power 2 → three acc_en pulses spaced 8 cycles apart, each 16, with no dropped samples.
- clear asserted mid-window after 5 of 8 samples → no acc_en from that window; next window counts from 0.
  - Also check: clear coincident with the 8th power_en → no acc_en for that window.
- rst_n deasserted low mid-window with samples in flight → all outputs 0 immediately.
  - After release, first power_en only for new in_en.
  - With POWER_INTEGRATOR_PEAK_EN defined: peak_power resets to 0 and then tracks max, e.g. 9 from 1,9,4,0.

Source files
------------

// File: rtl/power_pkg.sv
// Shared definitions for the power detector: default widths, the window
// FSM state type and the accumulator width helper.
package power_pkg;

  localparam int DEF_IN_W         = 16;
  localparam int DEF_LOG2_LEN_MAX = 10;

  // Window FSM: IDLE waits for the first sample of a window, ACCUM is mid-window.
  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } win_state_t;

  // Widest window sum: 2^log2_len_max samples of a 2*in_w-bit power.
  function automatic int acc_width(input int in_w, input int log2_len_max);
    return 2 * in_w + log2_len_max;
  endfunction

endpackage

// File: rtl/mag_sq_pipe.sv
// Three-stage |x|^2 = re^2 + im^2 pipeline with a travelling valid bit.
// Stage 1 registers the sample, stage 2 the signed squares, stage 3 their
// unsigned sum. Datapath stages only load when their valid input is high.
module mag_sq_pipe #(
  parameter int IN_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [IN_W-1:0] re,
  input  logic signed [IN_W-1:0] im,
  input  logic                   in_en,
  output logic [2*IN_W-1:0]      power,
  output logic                   power_en
);

  localparam int PW = 2 * IN_W;

  logic signed [IN_W-1:0] re_s1_reg, im_s1_reg;
  logic                   v1_reg;
  logic signed [PW-1:0]   re_ext, im_ext;
  logic signed [PW-1:0]   sq_re_reg, sq_im_reg;
  logic                   v2_reg;
  logic [PW-1:0]          pow_reg;
  logic                   v3_reg;

  // Sign-extend before squaring so the product is full precision; the
  // largest square, (-2^(IN_W-1))^2, still fits as a positive PW-bit value.
  assign re_ext = {{IN_W{re_s1_reg[IN_W-1]}}, re_s1_reg};
  assign im_ext = {{IN_W{im_s1_reg[IN_W-1]}}, im_s1_reg};

  // Stage 1: capture the incoming sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_s1_reg <= '0;
      im_s1_reg <= '0;
      v1_reg    <= 1'b0;
    end else begin
      v1_reg <= in_en;
      if (in_en) begin
        re_s1_reg <= re;
        im_s1_reg <= im;
      end
    end
  end

  // Stage 2: signed squares of both components.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_re_reg <= '0;
      sq_im_reg <= '0;
      v2_reg    <= 1'b0;
    end else begin
      v2_reg <= v1_reg;
      if (v1_reg) begin
        sq_re_reg <= re_ext * re_ext;
        sq_im_reg <= im_ext * im_ext;
      end
    end
  end

  // Stage 3: unsigned sum; max is 2^(PW-1), so PW bits never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pow_reg <= '0;
      v3_reg  <= 1'b0;
    end else begin
      v3_reg <= v2_reg;
      if (v2_reg) begin
        pow_reg <= $unsigned(sq_re_reg) + $unsigned(sq_im_reg);
      end
    end
  end

  assign power    = pow_reg;
  assign power_en = v3_reg;

endmodule

// File: rtl/power_integrator.sv
// Magnitude-squared power detector with 2^k-sample window integration.
// Emits the window sum (MEAN_MODE=0) or the truncated mean (MEAN_MODE=1).
// Optional feature macro POWER_INTEGRATOR_PEAK_EN adds peak_power, the
// largest per-sample power of each completed window.
module power_integrator
  import power_pkg::*;
#(
  parameter int IN_W         = DEF_IN_W,
  parameter int LOG2_LEN_MAX = DEF_LOG2_LEN_MAX,
  parameter int MEAN_MODE    = 0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic signed [IN_W-1:0]               re,
  input  logic signed [IN_W-1:0]               im,
  input  logic                                 in_en,
  input  logic [$clog2(LOG2_LEN_MAX+1)-1:0]    log2_len,
  input  logic                                 clear,
  output logic [2*IN_W-1:0]                    power,
  output logic                                 power_en,
  output logic [2*IN_W+LOG2_LEN_MAX-1:0]       acc_power,
  output logic                                 acc_en,
  output logic [LOG2_LEN_MAX:0]                sample_cnt
`ifdef POWER_INTEGRATOR_PEAK_EN
  ,
  output logic [2*IN_W-1:0]                    peak_power
`endif
);

  localparam int KW = $clog2(LOG2_LEN_MAX + 1);
  localparam int PW = 2 * IN_W;
  localparam int AW = acc_width(IN_W, LOG2_LEN_MAX);
  localparam int CW = LOG2_LEN_MAX + 1;

  win_state_t     state_reg, state_next;
  logic [KW-1:0]  k_reg, k_next;
  logic [AW-1:0]  acc_reg, acc_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [AW-1:0]  acc_power_reg, acc_power_next;
  logic           acc_en_reg, acc_en_next;

  logic [KW-1:0]  k_clamped, k_eff;
  logic [AW-1:0]  sum_val, result_val;
  logic [CW-1:0]  cnt_inc, target;
  logic           take, win_done;

  mag_sq_pipe #(
    .IN_W(IN_W)
  ) u_mag_sq_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .re      (re),
    .im      (im),
    .in_en   (in_en),
    .power   (power),
    .power_en(power_en)
  );

  // Out-of-range window lengths saturate at the largest supported window.
  assign k_clamped = (log2_len > KW'(LOG2_LEN_MAX)) ? KW'(LOG2_LEN_MAX) : log2_len;
  // k is only sampled on the first sample of a window; later samples reuse it.
  assign k_eff     = (state_reg == IDLE) ? k_clamped : k_reg;
  assign sum_val   = acc_reg + {{(AW-PW){1'b0}}, power};
  assign cnt_inc   = cnt_reg + {{(CW-1){1'b0}}, 1'b1};
  assign target    = {{(CW-1){1'b0}}, 1'b1} << k_eff;
  // clear wins over a coincident sample, including the one closing a window.
  assign take      = power_en && !clear;
  assign win_done  = take && (cnt_inc == target);
  assign result_val = (MEAN_MODE != 0) ? (sum_val >> k_eff) : sum_val;

  // Window FSM state and accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      k_reg         <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      acc_power_reg <= '0;
      acc_en_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      k_reg         <= k_next;
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      acc_power_reg <= acc_power_next;
      acc_en_reg    <= acc_en_next;
    end
  end

  // Next-state logic: accumulate, close the window on the 2^k-th sample, or abort.
  always_comb begin
    state_next     = state_reg;
    k_next         = k_reg;
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;
    acc_power_next = acc_power_reg;
    acc_en_next    = 1'b0;
    if (clear) begin
      state_next = IDLE;
      acc_next   = '0;
      cnt_next   = '0;
    end else if (take) begin
      k_next = k_eff;
      if (win_done) begin
        acc_power_next = result_val;
        acc_en_next    = 1'b1;
        acc_next       = '0;
        cnt_next       = '0;
        state_next     = IDLE;
      end else begin
        acc_next   = sum_val;
        cnt_next   = cnt_inc;
        state_next = ACCUM;
      end
    end
  end

  assign acc_power  = acc_power_reg;
  assign acc_en     = acc_en_reg;
  assign sample_cnt = cnt_reg;

`ifdef POWER_INTEGRATOR_PEAK_EN
  logic [PW-1:0] peak_run_reg, peak_run_next;
  logic [PW-1:0] peak_out_reg, peak_out_next;
  logic [PW-1:0] peak_cand;

  // Running max including the sample being taken this cycle.
  assign peak_cand = (power > peak_run_reg) ? power : peak_run_reg;

  // Peak registers: running max and the value published with acc_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_run_reg <= '0;
      peak_out_reg <= '0;
    end else begin
      peak_run_reg <= peak_run_next;
      peak_out_reg <= peak_out_next;
    end
  end

  // Peak tracking follows the accumulator: cleared on abort and window end.
  always_comb begin
    peak_run_next = peak_run_reg;
    peak_out_next = peak_out_reg;
    if (clear) begin
      peak_run_next = '0;
    end else if (win_done) begin
      peak_out_next = peak_cand;
      peak_run_next = '0;
    end else if (take) begin
      peak_run_next = peak_cand;
    end
  end

  assign peak_power = peak_out_reg;
`endif

endmodule
